// File: rtl/bongo_pkg.sv
// Shared types for the bongo pad event decoder: event codes, pad bit positions,
// debounce FSM states and the raw pad classifier.
package bongo_pkg;

  typedef enum logic [1:0] {
    NONE  = 2'b00,
    RIGHT = 2'b01,
    LEFT  = 2'b10,
    BOTH  = 2'b11
  } evt_code_t;

  // Each side of the bongo reports on two pad bits.
  localparam int PAD_LEFT_HI  = 3;
  localparam int PAD_RIGHT_HI = 2;
  localparam int PAD_LEFT_LO  = 1;
  localparam int PAD_RIGHT_LO = 0;

  typedef enum logic {
    STABLE    = 1'b0,
    CANDIDATE = 1'b1
  } deb_state_t;

  function automatic evt_code_t classify(input logic [3:0] pads);
    logic left_hit;
    logic right_hit;
    evt_code_t code;
    left_hit  = pads[PAD_LEFT_HI] | pads[PAD_LEFT_LO];
    right_hit = pads[PAD_RIGHT_HI] | pads[PAD_RIGHT_LO];
    if (left_hit && right_hit) code = BOTH;
    else if (left_hit)         code = LEFT;
    else if (right_hit)        code = RIGHT;
    else                       code = NONE;
    return code;
  endfunction

endpackage

// File: rtl/bongo_event_fifo.sv
// First-word-fall-through event queue; a push into a full queue is only
// accepted when a pop frees a slot in the same cycle, otherwise it is dropped.
module bongo_event_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = bongo_pkg::evt_code_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     push_data,
  input  logic pop_ready,
  output logic valid,
  output T     head,
  output logic overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  T                 mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [OCC_W-1:0] occupancy;
  logic             full;
  logic             pop;
  logic             wr_en;

  assign full  = (occupancy == OCC_W'(DEPTH));
  assign valid = (occupancy != '0);
  assign pop   = valid & pop_ready;
  assign wr_en = push & (~full | pop);
  assign head  = valid ? mem[rd_ptr] : T'(0);

  // NOTE: the storage array has no reset; occupancy alone decides what is
  // visible, so clearing the data would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
      overflow  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/bongo_event_decoder.sv
// Bongo pad decoder: synchronises the pad nibble, samples it on a slow tick,
// debounces the left/right/both class and queues an event per new hit class.
module bongo_event_decoder #(
  parameter int SAMPLE_DIV       = 400000,
  parameter int DEBOUNCE_SAMPLES = 3,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] pads,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [1:0] evt_code,
  output logic [1:0] stable_class,
  output logic       overflow
);

  import bongo_pkg::*;

  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam int CNT_W = DEBOUNCE_SAMPLES;

  logic [3:0]       pads_meta;
  logic [3:0]       pads_sync;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  evt_code_t        raw;
  deb_state_t       state;
  evt_code_t        candidate;
  logic [CNT_W-1:0] deb_cnt;
  evt_code_t        stable_q;
  logic             push;
  evt_code_t        push_code;
  logic             fifo_valid;
  evt_code_t        fifo_head;
  logic             fifo_ovf;

  // NOTE: every clocked block uses non-blocking assignments so each flop
  // samples the pre-edge value of its source, which is what makes the
  // two-stage synchroniser actually two stages deep.
  always_ff @(posedge clk) begin
    if (rst) begin
      pads_meta <= '0;
      pads_sync <= '0;
    end else begin
      pads_meta <= pads;
      pads_sync <= pads_meta;
    end
  end

  assign tick = (div_cnt == DIV_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst)       div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DIV_W'(1);
  end

  assign raw = classify(pads_sync);

  // A commit registers the push, so the queue write lands one cycle after the tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= STABLE;
      candidate <= NONE;
      deb_cnt   <= '0;
      stable_q  <= NONE;
      push      <= 1'b0;
      push_code <= NONE;
    end else begin
      push <= 1'b0;
      if (tick) begin
        case (state)
          STABLE: begin
            if (raw != stable_q) begin
              if (DEBOUNCE_SAMPLES == 1) begin
                stable_q  <= raw;
                push      <= (raw != NONE);
                push_code <= raw;
              end else begin
                candidate <= raw;
                deb_cnt   <= CNT_W'(1);
                state     <= CANDIDATE;
              end
            end
          end
          CANDIDATE: begin
            if (raw == candidate) begin
              if (deb_cnt == CNT_W'(DEBOUNCE_SAMPLES - 1)) begin
                stable_q  <= candidate;
                push      <= (candidate != NONE);
                push_code <= candidate;
                state     <= STABLE;
              end else begin
                deb_cnt <= deb_cnt + CNT_W'(1);
              end
            end else if (raw == stable_q) begin
              state <= STABLE;
            end else begin
              candidate <= raw;
              deb_cnt   <= CNT_W'(1);
            end
          end
          default: state <= STABLE;
        endcase
      end
    end
  end

  bongo_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (evt_code_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_code),
    .pop_ready (evt_ready),
    .valid     (fifo_valid),
    .head      (fifo_head),
    .overflow  (fifo_ovf)
  );

  // Outputs are forced low while rst is held, not just after it is sampled.
  assign evt_valid    = fifo_valid & ~rst;
  assign evt_code     = rst ? 2'b00 : fifo_head;
  assign stable_class = rst ? 2'b00 : stable_q;
  assign overflow     = fifo_ovf & ~rst;

endmodule
